// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the CONV host/memory side.
package conv_pkg;

  localparam int unsigned CONV_DW     = 20;
  localparam int unsigned CONV_IMG_AW = 12;
  localparam int unsigned CONV_L1_AW  = 10;
  localparam int unsigned CONV_TO_W   = 27;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_DONE
  } conv_state_e;

endpackage

// File: rtl/conv_sdp_ram.sv
// One write port, two registered read ports; reads return pre-write data.
module conv_sdp_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re_a,
  input  logic          i_clr_a,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic          i_re_b,
  input  logic          i_clr_b,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [DEPTH];

  // Array has no reset so it keeps its contents across a mid-run reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else begin
      if (i_clr_a)     o_rdata_a <= '0;
      else if (i_re_a) o_rdata_a <= r_mem[i_raddr_a];
      if (i_clr_b)     o_rdata_b <= '0;
      else if (i_re_b) o_rdata_b <= r_mem[i_raddr_b];
    end
  end

endmodule

// File: rtl/conv_host_mem.sv
// Host/memory end of the CONV interface: image ROM, L0/L1 layer memories,
// start handshake FSM, write counters and run timeout.
module conv_host_mem
  import conv_pkg::*;
#(
  parameter int unsigned DW     = CONV_DW,
  parameter int unsigned IMG_AW = CONV_IMG_AW,
  parameter int unsigned L1_AW  = CONV_L1_AW,
  parameter int unsigned TO_W   = CONV_TO_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_we,
  input  logic [IMG_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic [2:0]        dbg_sel,
  input  logic [IMG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel,
  output logic              done,
  output logic              timeout,
  output logic [IMG_AW:0]   wr_cnt0,
  output logic [L1_AW:0]    wr_cnt1
);

  // Terminal compare one below all-ones: DONE is reached after 2**TO_W-1 active cycles.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  conv_state_e     r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_busy_q, r_timeout;
  logic [IMG_AW:0] r_wr_cnt0;
  logic [L1_AW:0]  r_wr_cnt1;
  logic [2:0]      r_cd_sel, r_dbg_sel;
  logic            w_launch, w_active, w_run, w_to_hit, w_busy_fall, w_ld_ok;
  logic            w_wr_l0, w_wr_l1, w_rd_l0, w_rd_l1;
  logic [DW-1:0]   w_l0_dbg, w_l0_cd, w_l1_dbg, w_l1_cd, w_img_rdb_unused;

  assign w_launch    = (r_state == ST_IDLE) && start;
  assign w_active    = (r_state == ST_REQ) || (r_state == ST_RUN);
  assign w_run       = (r_state == ST_RUN);
  assign w_ld_ok     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_to_hit    = w_active && (r_to_cnt == TO_LAST);
  assign w_busy_fall = r_busy_q && !busy;

  assign w_wr_l0 = cwr && (csel == CSEL_L0);
  assign w_wr_l1 = cwr && (csel == CSEL_L1);
  assign w_rd_l0 = crd && (csel == CSEL_L0);
  assign w_rd_l1 = crd && (csel == CSEL_L1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_to_hit)  w_state_nxt = ST_DONE;
        else if (busy) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (w_to_hit || w_busy_fall) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_to_cnt  <= '0;
      r_busy_q  <= 1'b0;
      r_timeout <= 1'b0;
      r_wr_cnt0 <= '0;
      r_wr_cnt1 <= '0;
      r_cd_sel  <= '0;
      r_dbg_sel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy_q  <= busy;
      r_dbg_sel <= dbg_sel;
      if (w_rd_l0 || w_rd_l1) r_cd_sel <= csel;
      if (w_launch) begin
        r_to_cnt  <= '0;
        r_timeout <= 1'b0;
        r_wr_cnt0 <= '0;
        r_wr_cnt1 <= '0;
      end else begin
        if (w_active && (r_to_cnt != '1)) r_to_cnt <= r_to_cnt + 1'b1;
        if (w_to_hit) r_timeout <= 1'b1;
        if (w_active && w_wr_l0 && (r_wr_cnt0 != '1)) r_wr_cnt0 <= r_wr_cnt0 + 1'b1;
        if (w_active && w_wr_l1 && (r_wr_cnt1 != '1)) r_wr_cnt1 <= r_wr_cnt1 + 1'b1;
      end
    end
  end

  assign ready   = (r_state == ST_REQ);
  assign done    = (r_state == ST_DONE);
  assign timeout = r_timeout;
  assign wr_cnt0 = r_wr_cnt0;
  assign wr_cnt1 = r_wr_cnt1;

  // Each bank's read register only updates on its own select, so muxing by the
  // last valid select makes cdata_rd hold across idle or invalid-select reads.
  always_comb begin
    cdata_rd = w_l0_cd;
    if (r_cd_sel == CSEL_L1) cdata_rd = w_l1_cd;
  end

  always_comb begin
    dbg_data = '0;
    case (r_dbg_sel)
      CSEL_L0: dbg_data = w_l0_dbg;
      CSEL_L1: dbg_data = w_l1_dbg;
      default: dbg_data = '0;
    endcase
  end

  conv_sdp_ram #(.DEPTH(1 << IMG_AW), .AW(IMG_AW), .DW(DW)) u_img (
    .clk       (clk),
    .reset     (reset),
    .i_we      (ld_we && w_ld_ok),
    .i_waddr   (ld_addr),
    .i_wdata   (ld_data),
    .i_re_a    (w_run),
    .i_clr_a   (!w_run),
    .i_raddr_a (iaddr),
    .o_rdata_a (idata),
    .i_re_b    (1'b0),
    .i_clr_b   (1'b0),
    .i_raddr_b ('0),
    .o_rdata_b (w_img_rdb_unused)
  );

  conv_sdp_ram #(.DEPTH(1 << IMG_AW), .AW(IMG_AW), .DW(DW)) u_l0 (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_wr_l0),
    .i_waddr   (caddr_wr),
    .i_wdata   (cdata_wr),
    .i_re_a    (1'b1),
    .i_clr_a   (1'b0),
    .i_raddr_a (dbg_addr),
    .o_rdata_a (w_l0_dbg),
    .i_re_b    (w_rd_l0),
    .i_clr_b   (1'b0),
    .i_raddr_b (caddr_rd),
    .o_rdata_b (w_l0_cd)
  );

  conv_sdp_ram #(.DEPTH(1 << L1_AW), .AW(L1_AW), .DW(DW)) u_l1 (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_wr_l1),
    .i_waddr   (caddr_wr[L1_AW-1:0]),
    .i_wdata   (cdata_wr),
    .i_re_a    (1'b1),
    .i_clr_a   (1'b0),
    .i_raddr_a (dbg_addr[L1_AW-1:0]),
    .o_rdata_a (w_l1_dbg),
    .i_re_b    (w_rd_l1),
    .i_clr_b   (1'b0),
    .i_raddr_b (caddr_rd[L1_AW-1:0]),
    .o_rdata_b (w_l1_cd)
  );

endmodule
